counter_timer_seq: RTL and testbench

- Hardware sequencer that drives the register port of one counter_timer_low instance (config, reload value) through a programmed table of delays, with no CPU intervention between steps.
- Each step: load the delay, arm the timer as a one-shot down-counter, wait for its stop condition, disarm, then advance.
- Sits between the housekeeping/Wishbone register block (host side) and counter_timer_low (timer side).
- Signals sequence completion with a one-cycle pulse.

---
 rtl/ctseq_pkg.sv | 24 ++
 rtl/counter_timer_seq_if.sv | 27 ++
 rtl/ctseq_table.sv | 36 +++
 rtl/counter_timer_seq.sv | 169 ++++++++++++++++
 tb/tb_counter_timer_seq.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctseq_pkg.sv
// Shared definitions for counter_timer_seq: FSM state encoding, the timer
// configuration words written on arm/disarm, and the ctl_di field layout.
package ctseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    SETTLE,
    WAIT,
    DISARM,
    ABORT
  } ctseq_state_e;

  // enable | oneshot, count down, no chaining, timer irq off
  localparam logic [31:0] TMR_CFG_ARM = 32'h0000_0003;
  localparam logic [31:0] TMR_CFG_OFF = 32'h0000_0000;

  localparam int CTL_START    = 0;
  localparam int CTL_LOOP     = 1;
  localparam int CTL_ABORT    = 2;
  localparam int CTL_LAST_LSB = 8;

endpackage

// File: rtl/counter_timer_seq_if.sv
// Host-side register port of counter_timer_seq: delay table writes, control
// writes and status. master = host register block, slave = sequencer.
interface counter_timer_seq_if #(
  parameter int IDX_W = 2
) ();
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_idx;
  logic [31:0]      tbl_di;
  logic             ctl_we;
  logic [31:0]      ctl_di;
  logic             busy;
  logic [IDX_W-1:0] cur_idx;
  logic             done;
  logic             aborted;
  logic             done_irq;
  logic             irq_step;

  modport master (
    output tbl_we, tbl_idx, tbl_di, ctl_we, ctl_di,
    input  busy, cur_idx, done, aborted, done_irq, irq_step
  );

  modport slave (
    input  tbl_we, tbl_idx, tbl_di, ctl_we, ctl_di,
    output busy, cur_idx, done, aborted, done_irq, irq_step
  );
endinterface

// File: rtl/ctseq_table.sv
// DEPTH x 32 delay table: one write port, one combinational read port,
// contents cleared by resetn.
module ctseq_table #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  // next table contents: hold, or replace the addressed entry
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // table storage
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/counter_timer_seq.sv
// Delay-table sequencer driving the register port of a counter_timer_low.
// Optional macro CTSEQ_STEP_IRQ_EN: when defined, irq_step pulses once per
// completed step; otherwise irq_step is tied low.
//
// state  | meaning
// IDLE   | waiting for a start write
// LOAD   | write table[cur_idx] into the timer reload value
// ARM    | enable timer as one-shot down-counter
// SETTLE | timer clears its stale stop flag; tmr_stop ignored
// WAIT   | wait for tmr_stop
// DISARM | disable timer, advance / wrap / finish
// ABORT  | disable timer, flag aborted, return to IDLE
module counter_timer_seq
  import ctseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic                clkin,
  input  logic                resetn,
  counter_timer_seq_if.slave  host,
  output logic [3:0]          tmr_val_we,
  output logic [31:0]         tmr_val_di,
  output logic                tmr_cfg_we,
  output logic [31:0]         tmr_cfg_di,
  input  logic                tmr_stop
);

  ctseq_state_e     state_q, state_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             loop_q, loop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             done_irq_q, done_irq_d;
  logic [31:0]      tbl_rdata;
  logic             start_req, abort_req;
  logic             unused_ctl;
`ifdef CTSEQ_STEP_IRQ_EN
  logic             step_pulse;
`endif

  ctseq_table #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
    .clkin (clkin),
    .resetn(resetn),
    .we    (host.tbl_we),
    .waddr (host.tbl_idx),
    .wdata (host.tbl_di),
    .raddr (cur_idx_q),
    .rdata (tbl_rdata)
  );

  assign start_req  = host.ctl_we & host.ctl_di[CTL_START];
  assign abort_req  = host.ctl_we & host.ctl_di[CTL_ABORT];
  assign unused_ctl = ^{host.ctl_di[31:CTL_LAST_LSB+IDX_W], host.ctl_di[CTL_LAST_LSB-1:CTL_ABORT+1]};

  // next-state, sequencing registers and timer register-port writes
  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    last_idx_d = last_idx_q;
    loop_d     = loop_q;
    busy_d     = busy_q;
    done_d     = done_q;
    aborted_d  = aborted_q;
    done_irq_d = 1'b0;
    tmr_val_we = 4'h0;
    tmr_val_di = 32'h0;
    tmr_cfg_we = 1'b0;
    tmr_cfg_di = TMR_CFG_OFF;
`ifdef CTSEQ_STEP_IRQ_EN
    step_pulse = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_req && !abort_req) begin
          state_d    = LOAD;
          loop_d     = host.ctl_di[CTL_LOOP];
          last_idx_d = host.ctl_di[CTL_LAST_LSB +: IDX_W];
          cur_idx_d  = '0;
          done_d     = 1'b0;
          aborted_d  = 1'b0;
          busy_d     = 1'b1;
        end
      end
      LOAD: begin
        tmr_val_we = 4'hF;
        tmr_val_di = tbl_rdata;
        state_d    = ARM;
      end
      ARM: begin
        tmr_cfg_we = 1'b1;
        tmr_cfg_di = TMR_CFG_ARM;
        state_d    = SETTLE;
      end
      SETTLE: state_d = WAIT;
      WAIT: if (tmr_stop) state_d = DISARM;
      DISARM: begin
        tmr_cfg_we = 1'b1;
`ifdef CTSEQ_STEP_IRQ_EN
        step_pulse = 1'b1;
`endif
        if (cur_idx_q != last_idx_q) begin
          cur_idx_d = cur_idx_q + IDX_W'(1);
          state_d   = LOAD;
        end else if (loop_q) begin
          cur_idx_d = '0;
          state_d   = LOAD;
        end else begin
          state_d    = IDLE;
          done_d     = 1'b1;
          done_irq_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      ABORT: begin
        tmr_cfg_we = 1'b1;
        aborted_d  = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort overrides whatever the active state decided (stop, wrap, finish)
    if (abort_req && state_q != IDLE && state_q != ABORT) begin
      state_d    = ABORT;
      cur_idx_d  = cur_idx_q;
      busy_d     = 1'b1;
      done_d     = done_q;
      done_irq_d = 1'b0;
    end
  end

  // sequencer state and status registers
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cur_idx_q  <= '0;
      last_idx_q <= '0;
      loop_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      done_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      last_idx_q <= last_idx_d;
      loop_q     <= loop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      done_irq_q <= done_irq_d;
    end
  end

  assign host.busy     = busy_q;
  assign host.cur_idx  = cur_idx_q;
  assign host.done     = done_q;
  assign host.aborted  = aborted_q;
  assign host.done_irq = done_irq_q;
`ifdef CTSEQ_STEP_IRQ_EN
  assign host.irq_step = step_pulse;
`else
  assign host.irq_step = 1'b0;
`endif

endmodule

// File: tb/tb_counter_timer_seq.sv
module tb_counter_timer_seq;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
`ifdef CTSEQ_STEP_IRQ_EN
  localparam bit STEP_IRQ = 1'b1;
`else
  localparam bit STEP_IRQ = 1'b0;
`endif

  logic        clkin = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  tmr_val_we;
  logic [31:0] tmr_val_di;
  logic        tmr_cfg_we;
  logic [31:0] tmr_cfg_di;
  logic        tmr_stop;

  always #5 clkin = ~clkin;

  counter_timer_seq_if #(.IDX_W(IDX_W)) host ();

  counter_timer_seq #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clkin     (clkin),
    .resetn    (resetn),
    .host      (host),
    .tmr_val_we(tmr_val_we),
    .tmr_val_di(tmr_val_di),
    .tmr_cfg_we(tmr_cfg_we),
    .tmr_cfg_di(tmr_cfg_di),
    .tmr_stop  (tmr_stop)
  );

  // Behavioural stand-in for counter_timer_low: one-shot down-counter whose
  // stop flag rises once the count has reached zero, cleared on re-arm.
  logic [31:0] t_val, t_cnt;
  logic        t_en, t_stop;
  always @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      t_val <= 0; t_cnt <= 0; t_en <= 0; t_stop <= 0;
    end else begin
      if (tmr_val_we == 4'hF) t_val <= tmr_val_di;
      if (tmr_cfg_we) begin
        t_en <= tmr_cfg_di[0];
        if (tmr_cfg_di[0]) begin
          t_cnt  <= t_val;
          t_stop <= 1'b0;
        end
      end else if (t_en && !t_stop) begin
        if (t_cnt == 0) t_stop <= 1'b1;
        else            t_cnt  <= t_cnt - 1;
      end
    end
  end
  assign tmr_stop = t_stop;

  // Event monitor, sampled mid-cycle
  int cyc = 0, done_cyc = 0, done_cnt = 0, step_cnt = 0, cfg_wr_cnt = 0, val_wr_cnt = 0;
  int idx_log[$];
  int load_cyc[$];
  always @(negedge clkin) begin
    if (tmr_val_we != 4'h0) begin
      idx_log.push_back(int'(host.cur_idx));
      load_cyc.push_back(cyc);
      val_wr_cnt++;
    end
    if (tmr_cfg_we) cfg_wr_cnt++;
    if (host.done_irq) begin done_cyc = cyc; done_cnt++; end
    if (host.irq_step) step_cnt++;
    cyc++;
  end

  int errors = 0, checks = 0;
  int ref_tbl [DEPTH];

  // Reference: a step with delay N occupies N+5 cycles; sum over steps 0..last
  function automatic int seq_cycles(int last);
    int s = 0;
    for (int i = 0; i <= last; i++) s += ref_tbl[i] + 5;
    return s;
  endfunction

  task automatic tick();
    @(posedge clkin); #1;
  endtask

  task automatic write_tbl(int i, int v);
    host.tbl_we = 1'b1; host.tbl_idx = IDX_W'(i); host.tbl_di = v;
    ref_tbl[i] = v;
    tick();
    host.tbl_we = 1'b0;
  endtask

  task automatic ctl(bit start, bit lp, bit abrt, int last);
    logic [31:0] d = 32'h0;
    d[0] = start; d[1] = lp; d[2] = abrt; d[8 +: IDX_W] = IDX_W'(last);
    host.ctl_we = 1'b1; host.ctl_di = d;
    tick();
    host.ctl_we = 1'b0; host.ctl_di = 32'h0;
  endtask

  task automatic wait_done(int d0, output bit ok);
    int n = 0;
    while (done_cnt == d0 && n < 1000) begin tick(); n++; end
    ok = (done_cnt != d0);
  endtask

  task automatic test_reset();
    checks++;
    if ({host.busy, host.done, host.aborted, host.done_irq, host.irq_step, host.cur_idx,
         tmr_val_we, tmr_cfg_we, tmr_val_di, tmr_cfg_di} !== '0) begin
      errors++; $display("FAIL reset_outputs: busy=%b done=%b aborted=%b cur_idx=%0d val_we=%h cfg_we=%b, required all 0",
                         host.busy, host.done, host.aborted, host.cur_idx, tmr_val_we, tmr_cfg_we);
    end
    resetn = 1'b1;
    tick(); tick();
    checks++;
    if ({host.busy, host.done, tmr_val_we, tmr_cfg_we} !== '0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b done=%b val_we=%h cfg_we=%b, required 0", host.busy, host.done, tmr_val_we, tmr_cfg_we);
    end
  endtask

  task automatic run_and_check(string name, int last, bit test_idx);
    int b = idx_log.size(), d0 = done_cnt, s0 = step_cnt;
    bit ok;
    ctl(1, 0, 0, last);
    wait_done(d0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: done_irq not seen, required within 1000 cycles", name); return; end
    checks++;
    if (done_cyc - load_cyc[b] != seq_cycles(last)) begin
      errors++; $display("FAIL %s_latency: got %0d cycles, required %0d", name, done_cyc - load_cyc[b], seq_cycles(last));
    end
    checks++;
    if (host.done !== 1'b1 || host.busy !== 1'b0) begin
      errors++; $display("FAIL %s_status: done=%b busy=%b, required done=1 busy=0", name, host.done, host.busy);
    end
    checks++;
    if (step_cnt - s0 != (STEP_IRQ ? last + 1 : 0)) begin
      errors++; $display("FAIL %s_irq_step: got %0d pulses, required %0d", name, step_cnt - s0, STEP_IRQ ? last + 1 : 0);
    end
    if (test_idx) begin
      checks++;
      if (idx_log.size() - b != last + 1) begin
        errors++; $display("FAIL %s_step_count: got %0d steps, required %0d", name, idx_log.size() - b, last + 1);
      end else begin
        for (int k = 0; k <= last; k++) begin
          checks++;
          if (idx_log[b+k] != k) begin
            errors++; $display("FAIL %s_cur_idx: step %0d idx %0d, required %0d", name, k, idx_log[b+k], k);
          end
        end
      end
    end
  endtask

  task automatic test_single();
    write_tbl(0, 5); write_tbl(1, 3); write_tbl(2, 0); write_tbl(3, 7);
    run_and_check("single", 3, 1);
  endtask

  task automatic test_loop_abort();
    int b = idx_log.size(), n = 0;
    ctl(1, 1, 0, 3);
    while (idx_log.size() < b + 6 && n < 500) begin tick(); n++; end
    checks++;
    if (idx_log.size() < b + 6) begin
      errors++; $display("FAIL loop_timeout: %0d loads, required 6", idx_log.size() - b);
      return;
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (idx_log[b+k] != k % 4) begin
        errors++; $display("FAIL loop_seq: step %0d idx %0d, required %0d", k, idx_log[b+k], k % 4);
      end
    end
    checks++;
    if (host.done !== 1'b0) begin errors++; $display("FAIL loop_done: done=%b, required 0", host.done); end
    tick(); tick();           // ARM -> SETTLE -> WAIT of entry 1
    checks++;
    if (host.cur_idx !== 2'd1 || t_en !== 1'b1) begin
      errors++; $display("FAIL loop_wait: cur_idx=%0d t_en=%b, required 1/1", host.cur_idx, t_en);
    end
    ctl(0, 0, 1, 0);
    checks++;
    if (tmr_cfg_we !== 1'b1 || tmr_cfg_di !== 32'h0) begin
      errors++; $display("FAIL abort_write: cfg_we=%b cfg_di=%h, required 1/00000000", tmr_cfg_we, tmr_cfg_di);
    end
    tick();
    checks++;
    if (host.aborted !== 1'b1 || host.busy !== 1'b0 || t_en !== 1'b0 || host.done !== 1'b0) begin
      errors++; $display("FAIL abort_status: aborted=%b busy=%b t_en=%b done=%b, required 1/0/0/0", host.aborted, host.busy, t_en, host.done);
    end
  endtask

  task automatic test_start_abort_idle();
    int v0 = val_wr_cnt, c0 = cfg_wr_cnt;
    ctl(1, 0, 1, 3);
    repeat (4) tick();
    checks++;
    if (host.busy !== 1'b0 || val_wr_cnt != v0 || cfg_wr_cnt != c0) begin
      errors++; $display("FAIL start_abort_idle: busy=%b val_writes=%0d cfg_writes=%0d, required 0/0/0", host.busy, val_wr_cnt - v0, cfg_wr_cnt - c0);
    end
  endtask

  task automatic test_back_to_back();
    int b = idx_log.size(), d0 = done_cnt;
    bit ok;
    ctl(1, 0, 0, 2);
    tick();
    ctl(1, 1, 0, 0);         // ignored while busy
    wait_done(d0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_start_timeout: done_irq not seen"); return; end
    checks++;
    if (idx_log.size() - b != 3 || done_cyc - load_cyc[b] != seq_cycles(2)) begin
      errors++; $display("FAIL busy_start: steps=%0d cycles=%0d, required 3/%0d", idx_log.size() - b, done_cyc - load_cyc[b], seq_cycles(2));
    end
  endtask

  task automatic test_rewrite();
    int b = idx_log.size(), d0 = done_cnt, s0 = step_cnt;
    bit ok;
    ctl(1, 0, 0, 2);
    tick();
    write_tbl(2, 9);
    wait_done(d0, ok);
    checks++;
    if (!ok || idx_log.size() - b != 3) begin errors++; $display("FAIL rewrite_run: done=%b steps=%0d, required 1/3", ok, idx_log.size() - b); return; end
    checks++;
    if (done_cyc - load_cyc[b+2] != ref_tbl[2] + 5) begin
      errors++; $display("FAIL rewrite_step2: got %0d cycles, required %0d", done_cyc - load_cyc[b+2], ref_tbl[2] + 5);
    end
    checks++;
    if (step_cnt - s0 != (STEP_IRQ ? 3 : 0)) begin
      errors++; $display("FAIL rewrite_irq_step: got %0d, required %0d", step_cnt - s0, STEP_IRQ ? 3 : 0);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) write_tbl(i, $urandom_range(0, 12));
      run_and_check("random", $urandom_range(0, DEPTH - 1), 1);
    end
  endtask

  task automatic test_reset_mid();
    int b, d0;
    bit ok;
    write_tbl(0, 20);
    ctl(1, 0, 0, 3);
    repeat (5) tick();
    resetn = 1'b0;
    #2;
    checks++;
    if ({host.busy, host.done, host.aborted, host.done_irq, host.irq_step, host.cur_idx,
         tmr_val_we, tmr_cfg_we, tmr_val_di, tmr_cfg_di} !== '0 || t_en !== 1'b0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b cur_idx=%0d cfg_we=%b t_en=%b, required all 0", host.busy, host.done, host.cur_idx, tmr_cfg_we, t_en);
    end
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 0;
    tick();
    resetn = 1'b1;
    tick();
    b = idx_log.size(); d0 = done_cnt;
    ctl(1, 0, 0, 0);
    wait_done(d0, ok);
    checks++;
    if (!ok || done_cyc - load_cyc[b] != seq_cycles(0)) begin
      errors++; $display("FAIL reset_table_cleared: done=%b cycles=%0d, required 1/%0d", ok, done_cyc - load_cyc[b], seq_cycles(0));
    end
  endtask

  initial begin
    host.tbl_we = 0; host.tbl_idx = '0; host.tbl_di = 0;
    host.ctl_we = 0; host.ctl_di = 0;
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 0;
    repeat (3) tick();
    test_reset();
    test_single();
    test_loop_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_rewrite();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
